// File: rtl/fc_layer_mac_array.sv
// Fully connected layer: buffered input vector, LANES parallel MACs shared across neuron groups,
// bias add, floor rescale and saturation. Define FC_RELU_EN to clamp negative neurons to zero.
module fc_layer_mac_array #(
    parameter int PIX_WIDTH          = 8,
    parameter int WEIGHT_WIDTH       = 10,
    parameter int WEIGHT_FRACT_WIDTH = 5,
    parameter int IN_DIMENSION       = 200,
    parameter int OUT_DIMENSION      = 64,
    parameter int LANES              = 8,
    parameter int OUT_WIDTH          = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clk_en,
    input  logic [PIX_WIDTH-1:0]                     i_data,
    input  logic                                     i_valid,
    input  logic                                     i_sop,
    input  logic                                     i_eop,
    output logic                                     o_ready,
    output logic [OUT_WIDTH-1:0]                     o_data,
    output logic                                     o_valid,
    output logic                                     o_sop,
    output logic                                     o_eop,
    input  logic                                     i_ready,
    input  logic                                     wr_en,
    input  logic [$clog2(OUT_DIMENSION+1)-1:0]       wr_sel,
    input  logic [$clog2(IN_DIMENSION)-1:0]          wr_addr,
    input  logic [WEIGHT_WIDTH-1:0]                  wr_data,
    output logic                                     o_busy,
    output logic                                     o_len_err,
    output logic                                     o_wr_err
);
    localparam int G     = OUT_DIMENSION / LANES;
    localparam int IDX_W = $clog2(IN_DIMENSION);
    localparam int G_W   = (G > 1) ? $clog2(G) : 1;
    localparam int O_W   = (OUT_DIMENSION > 1) ? $clog2(OUT_DIMENSION) : 1;
    localparam int WA_W  = (G * IN_DIMENSION > 1) ? $clog2(G * IN_DIMENSION) : 1;
    localparam int PW    = PIX_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W = PW + $clog2(IN_DIMENSION);
    localparam int RW    = ((ACC_W + 1 > OUT_WIDTH) ? ACC_W + 1 : OUT_WIDTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIMENSION - 1);
    localparam logic [G_W-1:0]   LAST_G   = G_W'(G - 1);
    localparam logic [O_W-1:0]   LAST_O   = O_W'(OUT_DIMENSION - 1);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, widx;
    logic [IDX_W-1:0]  rd_i_q, rd_i_d;
    logic [G_W-1:0]    rd_g_q, rd_g_d;
    logic              issued_q, issued_d;
    logic              rd_v_q, rd_first_q, rd_last_q;
    logic [G_W-1:0]    rd_grp_q;
    logic              p_v_q, p_first_q, p_last_q;
    logic [G_W-1:0]    p_grp_q;
    logic              a_done_q;
    logic [G_W-1:0]    a_grp_q;
    logic [O_W-1:0]    out_idx_q, out_idx_d;
    logic              o_ready_q, o_ready_d, o_valid_q, o_valid_d;
    logic              o_sop_q, o_sop_d, o_eop_q, o_eop_d;
    logic [OUT_WIDTH-1:0] o_data_q, o_data_d;
    logic              o_busy_q, o_busy_d, len_err_q, len_err_d, wr_err_q, wr_err_d;

    logic              beat_ok, go_compute, rd_fire, x_we;
    logic [IDX_W-1:0]  x_waddr;
    logic [WA_W-1:0]   rd_addr, w_waddr;
    logic [G_W-1:0]    b_waddr, drain_g;
    logic              w_we, b_we;
    int                wr_lane, drain_l;
    logic [LANES*OUT_WIDTH-1:0] res_bus, drain_word;
    logic [OUT_WIDTH-1:0]       drain_pix;

    logic signed [PIX_WIDTH-1:0] xbuf [IN_DIMENSION];
    logic signed [PIX_WIDTH-1:0] x_rd_q;
    logic [LANES*OUT_WIDTH-1:0]  obuf [G];

    // Write decode: weights live per lane at (neuron/LANES)*IN + addr, biases per lane at neuron/LANES.
    always_comb begin
        w_we     = 1'b0;
        b_we     = 1'b0;
        wr_lane  = 0;
        w_waddr  = '0;
        b_waddr  = '0;
        wr_err_d = 1'b0;
        if (wr_en) begin
            if (state_q != ST_IDLE) begin
                wr_err_d = 1'b1;
            end else if (int'(wr_sel) < OUT_DIMENSION && int'(wr_addr) < IN_DIMENSION) begin
                w_we    = 1'b1;
                wr_lane = int'(wr_sel) % LANES;
                w_waddr = WA_W'((int'(wr_sel) / LANES) * IN_DIMENSION + int'(wr_addr));
            end else if (int'(wr_sel) == OUT_DIMENSION && int'(wr_addr) < OUT_DIMENSION) begin
                b_we    = 1'b1;
                wr_lane = int'(wr_addr) % LANES;
                b_waddr = G_W'(int'(wr_addr) / LANES);
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    assign rd_addr    = WA_W'(int'(rd_g_q) * IN_DIMENSION + int'(rd_i_q));
    assign drain_g    = G_W'(int'(out_idx_q) / LANES);
    assign drain_l    = int'(out_idx_q) % LANES;
    assign drain_word = obuf[drain_g];
    assign drain_pix  = drain_word[drain_l*OUT_WIDTH +: OUT_WIDTH];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_i_d     = rd_i_q;
        rd_g_d     = rd_g_q;
        issued_d   = issued_q;
        out_idx_d  = out_idx_q;
        o_valid_d  = o_valid_q;
        o_sop_d    = o_sop_q;
        o_eop_d    = o_eop_q;
        o_data_d   = o_data_q;
        len_err_d  = 1'b0;
        x_we       = 1'b0;
        x_waddr    = '0;
        widx       = '0;
        go_compute = 1'b0;
        beat_ok    = i_valid && o_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (beat_ok && i_sop) begin
                    x_we    = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_ok) begin
                    widx    = i_sop ? '0 : idx_q;
                    x_we    = 1'b1;
                    x_waddr = widx;
                    if (widx == LAST_IDX) begin
                        go_compute = 1'b1;
                        len_err_d  = !i_eop;
                        state_d    = ST_COMPUTE;
                    end else if (i_eop) begin
                        len_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d = widx + IDX_W'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                if (a_done_q && a_grp_q == LAST_G) begin
                    state_d   = ST_DRAIN;
                    out_idx_d = '0;
                    issued_d  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!o_valid_q || i_ready) begin
                    if (o_valid_q && o_eop_q) begin
                        o_valid_d = 1'b0;
                        o_sop_d   = 1'b0;
                        o_eop_d   = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        o_valid_d = 1'b1;
                        o_data_d  = drain_pix;
                        o_sop_d   = (out_idx_q == '0);
                        o_eop_d   = (out_idx_q == LAST_O);
                        out_idx_d = out_idx_q + O_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first read is issued on the eop edge itself so the MACs start immediately.
        rd_fire = go_compute || (state_q == ST_COMPUTE && !issued_q);
        if (rd_fire) begin
            if (rd_i_q == LAST_IDX) begin
                rd_i_d = '0;
                if (rd_g_q == LAST_G) begin
                    rd_g_d   = '0;
                    issued_d = 1'b1;
                end else begin
                    rd_g_d = rd_g_q + G_W'(1);
                end
            end else begin
                rd_i_d = rd_i_q + IDX_W'(1);
            end
        end
        o_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        o_busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rd_i_q     <= '0;
            rd_g_q     <= '0;
            issued_q   <= 1'b0;
            rd_v_q     <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_grp_q   <= '0;
            p_v_q      <= 1'b0;
            p_first_q  <= 1'b0;
            p_last_q   <= 1'b0;
            p_grp_q    <= '0;
            a_done_q   <= 1'b0;
            a_grp_q    <= '0;
            out_idx_q  <= '0;
            o_ready_q  <= 1'b1;
            o_valid_q  <= 1'b0;
            o_sop_q    <= 1'b0;
            o_eop_q    <= 1'b0;
            o_data_q   <= '0;
            o_busy_q   <= 1'b0;
            len_err_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_i_q     <= rd_i_d;
            rd_g_q     <= rd_g_d;
            issued_q   <= issued_d;
            rd_v_q     <= rd_fire;
            rd_first_q <= rd_fire && (rd_i_q == '0);
            rd_last_q  <= rd_fire && (rd_i_q == LAST_IDX);
            rd_grp_q   <= rd_g_q;
            p_v_q      <= rd_v_q;
            p_first_q  <= rd_first_q;
            p_last_q   <= rd_last_q;
            p_grp_q    <= rd_grp_q;
            a_done_q   <= p_v_q && p_last_q;
            a_grp_q    <= p_grp_q;
            out_idx_q  <= out_idx_d;
            o_ready_q  <= o_ready_d;
            o_valid_q  <= o_valid_d;
            o_sop_q    <= o_sop_d;
            o_eop_q    <= o_eop_d;
            o_data_q   <= o_data_d;
            o_busy_q   <= o_busy_d;
            len_err_q  <= len_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (x_we) xbuf[x_waddr] <= i_data;
            if (rd_fire) x_rd_q <= xbuf[rd_i_q];
            if (a_done_q) obuf[a_grp_q] <= res_bus;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [WEIGHT_WIDTH-1:0] wmem [G*IN_DIMENSION];
        logic signed [WEIGHT_WIDTH-1:0] bmem [G];
        logic signed [WEIGHT_WIDTH-1:0] w_rd_q, b_rd_q;
        logic signed [PW-1:0]           prod_q;
        logic signed [ACC_W-1:0]        acc_q, acc_sh;
        logic signed [RW-1:0]           r_full, r_act;
        logic [OUT_WIDTH-1:0]           r_sat;

        always_ff @(posedge clk) begin
            if (clk_en) begin
                if (w_we && wr_lane == gi) wmem[w_waddr] <= wr_data;
                if (b_we && wr_lane == gi) bmem[b_waddr] <= wr_data;
                if (rd_fire) w_rd_q <= wmem[rd_addr];
                if (p_v_q && p_last_q) b_rd_q <= bmem[p_grp_q];
                prod_q <= PW'(w_rd_q) * PW'(x_rd_q);
                if (p_v_q) acc_q <= p_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
            end
        end

        // Arithmetic shift floors toward minus infinity, which is the intended rounding.
        always_comb begin
            acc_sh = acc_q >>> WEIGHT_FRACT_WIDTH;
            r_full = RW'(acc_sh) + RW'(b_rd_q);
            r_act  = r_full;
`ifdef FC_RELU_EN
            if (r_full < 0) r_act = '0;
`else
            r_act  = r_full;
`endif
            if (r_act > SAT_MAX)      r_sat = OUT_WIDTH'(SAT_MAX);
            else if (r_act < SAT_MIN) r_sat = OUT_WIDTH'(SAT_MIN);
            else                      r_sat = r_act[OUT_WIDTH-1:0];
        end

        assign res_bus[gi*OUT_WIDTH +: OUT_WIDTH] = r_sat;
    end

    assign o_ready   = o_ready_q;
    assign o_valid   = o_valid_q;
    assign o_sop     = o_sop_q;
    assign o_eop     = o_eop_q;
    assign o_data    = o_data_q;
    assign o_busy    = o_busy_q;
    assign o_len_err = len_err_q;
    assign o_wr_err  = wr_err_q;
endmodule

// File: tb/tb_fc_layer_mac_array.sv
// Scoreboard bench for fc_layer_mac_array: directed frames push expected words, a monitor pops them.
module tb_fc_layer_mac_array;
    localparam int PIX = 8, WW = 10, FR = 5, IN = 4, OUT = 4, LN = 2, OW = 8;

    logic clk = 1'b0, rst_n = 1'b1, clk_en = 1'b1;
    logic [PIX-1:0] i_data = '0;
    logic i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_ready = 1'b1;
    logic o_ready, o_valid, o_sop, o_eop, o_busy, o_len_err, o_wr_err;
    logic [OW-1:0] o_data;
    logic wr_en = 1'b0;
    logic [$clog2(OUT+1)-1:0] wr_sel = '0;
    logic [$clog2(IN)-1:0] wr_addr = '0;
    logic [WW-1:0] wr_data = '0;

    typedef struct packed { logic sop; logic eop; logic [OW-1:0] data; } exp_t;
    exp_t exp_q[$];
    int n_checks = 0, n_pass = 0;

    fc_layer_mac_array #(.PIX_WIDTH(PIX), .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(FR),
        .IN_DIMENSION(IN), .OUT_DIMENSION(OUT), .LANES(LN), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .o_busy(o_busy), .o_len_err(o_len_err),
        .o_wr_err(o_wr_err));

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    // Monitor: a word transfers on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && clk_en && o_valid && i_ready) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected got=%0d sop=%b eop=%b", $signed(o_data), o_sop, o_eop);
            end else begin
                e = exp_q.pop_front();
                if (o_data == e.data && o_sop == e.sop && o_eop == e.eop) begin
                    n_pass++;
                    $display("out word=%0d sop=%b eop=%b ok", $signed(o_data), o_sop, o_eop);
                end else begin
                    $display("FAIL out_word got=%0d/%b/%b want=%0d/%b/%b", $signed(o_data), o_sop,
                             o_eop, $signed(e.data), e.sop, e.eop);
                end
            end
        end
    end

    task automatic push4(input int e0, input int e1, input int e2, input int e3);
        exp_t e;
        int v[4];
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
        for (int k = 0; k < 4; k++) begin
            e.sop = (k == 0); e.eop = (k == 3); e.data = OW'(v[k]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input int sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = 3'(sel); wr_addr = 2'(addr); wr_data = WW'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_all(input int wval, input int bstep);
        for (int n = 0; n < OUT; n++)
            for (int a = 0; a < IN; a++) wr(n, a, wval);
        for (int n = 0; n < OUT; n++) wr(OUT, n, n * bstep);
    endtask

    task automatic send_beat(input int d, input bit sop, input bit eop, output bit lerr);
        bit acc;
        acc = 1'b0;
        i_data = PIX'(d); i_sop = sop; i_eop = eop; i_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_ready) begin acc = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (acc) begin
            @(posedge clk); #1;
            lerr = o_len_err;
        end else begin
            check("beat_accept", 0, 1);
            lerr = 1'b0;
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic send_frame(input int x0, input int x1, input int x2, input int x3, output bit lerr);
        bit dummy;
        send_beat(x0, 1'b1, 1'b0, dummy);
        send_beat(x1, 1'b0, 1'b0, dummy);
        send_beat(x2, 1'b0, 1'b0, dummy);
        send_beat(x3, 1'b0, 1'b1, lerr);
    endtask

    task automatic latency(input string name);
        int cnt;
        cnt = 0;
        while (!o_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check(name, cnt, 11);
        $display("latency %s cycles=%0d", name, cnt);
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 300 && o_busy; t++) begin
            @(posedge clk); #1;
        end
        check({name, "_idle"}, int'(o_busy), 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ready"}, int'(o_ready), 1);
        check({p, "_valid"}, int'(o_valid), 0);
        check({p, "_sop"}, int'(o_sop), 0);
        check({p, "_eop"}, int'(o_eop), 0);
        check({p, "_data"}, int'(o_data), 0);
        check({p, "_busy"}, int'(o_busy), 0);
        check({p, "_len_err"}, int'(o_len_err), 0);
        check({p, "_wr_err"}, int'(o_wr_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lerr;
        logic [OW-1:0] held;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with latency and a 5-cycle backpressure window mid-drain.
        load_all(32, 1);
        push4(10, 11, 12, 13);
        send_frame(1, 2, 3, 4, lerr);
        check("basic_len_err", int'(lerr), 0);
        check("basic_ready_drop", int'(o_ready), 0);
        latency("basic_latency");
        check("basic_first_sop", int'(o_sop), 1);
        @(posedge clk); #1;
        i_ready = 1'b0;
        held = o_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", int'(o_valid), 1);
            check("bp_data_hold", int'(o_data), int'(held));
        end
        i_ready = 1'b1;
        wait_idle("basic");
        check("basic_ready_back", int'(o_ready), 1);

        // Write during COMPUTE is dropped.
        push4(10, 11, 12, 13);
        send_frame(1, 2, 3, 4, lerr);
        wr(0, 0, 0);
        check("wr_lock_err", int'(o_wr_err), 1);
        wait_idle("wrlock");

        // Short frame: eop on beat 2.
        send_beat(1, 1'b1, 1'b0, lerr);
        send_beat(2, 1'b0, 1'b1, lerr);
        check("short_len_err", int'(lerr), 1);
        check("short_ready", int'(o_ready), 1);
        repeat (20) @(posedge clk);
        #1;
        check("short_busy", int'(o_busy), 0);
        check("short_no_out", exp_q.size(), 0);

        // Long frame: beat 4 lacks eop, beat 5 is dropped.
        push4(10, 11, 12, 13);
        send_beat(1, 1'b1, 1'b0, lerr);
        send_beat(2, 1'b0, 1'b0, lerr);
        send_beat(3, 1'b0, 1'b0, lerr);
        send_beat(4, 1'b0, 1'b0, lerr);
        check("long_len_err", int'(lerr), 1);
        i_data = 8'd100; i_valid = 1'b1; i_eop = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_eop = 1'b0;
        wait_idle("long");

        // Reset during COMPUTE, then a fresh frame without reloading weights.
        send_frame(1, 2, 3, 4, lerr);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push4(10, 11, 12, 13);
        send_frame(1, 2, 3, 4, lerr);
        latency("post_rst_latency");
        wait_idle("post_rst");

        // Signed input with floor rescale on neuron 0.
        load_all(0, 0);
        wr(0, 0, 16);
`ifdef FC_RELU_EN
        push4(0, 0, 0, 0);
`else
        push4(-2, 0, 0, 0);
`endif
        send_frame(-3, 0, 0, 0, lerr);
        wait_idle("signed");

        // Positive and negative saturation.
        load_all(511, 0);
        push4(127, 127, 127, 127);
        send_frame(127, 127, 127, 127, lerr);
        wait_idle("sat_pos");
        load_all(-512, 0);
`ifdef FC_RELU_EN
        push4(0, 0, 0, 0);
`else
        push4(-128, -128, -128, -128);
`endif
        send_frame(127, 127, 127, 127, lerr);
        wait_idle("sat_neg");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
